// File: rtl/i_deserializer_sdr_if.sv
// Bus bundle for i_deserializer_sdr.
//   master : drives serial data, enable, bitslip and align start; observes the word outputs.
//   slave  : the deserializer itself.
// Signals:
//   d           serial data from the input buffer
//   en          sample enable
//   bitslip     slip request (acted on at its rising edge)
//   align_start 1-cycle pulse that starts auto-alignment
//   q           last completed parallel word
//   data_valid  1-cycle strobe when q updates
//   aligned     training pattern locked
//   align_fail  no phase matched the training pattern
interface i_deserializer_sdr_if #(
  parameter int unsigned WIDTH = 8
);
  logic             d;
  logic             en;
  logic             bitslip;
  logic             align_start;
  logic [WIDTH-1:0] q;
  logic             data_valid;
  logic             aligned;
  logic             align_fail;

  modport master (
    output d, en, bitslip, align_start,
    input  q, data_valid, aligned, align_fail
  );

  modport slave (
    input  d, en, bitslip, align_start,
    output q, data_valid, aligned, align_fail
  );
endinterface

// File: rtl/i_deserializer_sdr.sv
// Single-rate input deserializer. Samples serial data on every enabled rising edge and
// assembles WIDTH-bit words, MSB first. A bitslip rising edge (or an internal training slip)
// moves the word boundary one bit later.
// Optional feature macro: I_DESER_AUTO_ALIGN_EN compiles in a training FSM that slips until
// the received word equals TRAIN_PATTERN[WIDTH-1:0]. Without it, aligned/align_fail are 0 and
// align_start is ignored; the port list is the same in both builds.
// Ports:
//   i_clk  sample clock, rising edge
//   i_rst  synchronous active-high reset
//   bus    i_deserializer_sdr_if.slave (d, en, bitslip, align_start -> q, data_valid,
//          aligned, align_fail)
module i_deserializer_sdr #(
  parameter int unsigned WIDTH         = 8,
  parameter logic [15:0] TRAIN_PATTERN = 16'h5C
) (
  input logic                 i_clk,
  input logic                 i_rst,
  i_deserializer_sdr_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  // Only the last WIDTH-1 bits are kept; the current d supplies the final bit of a word.
  logic [WIDTH-2:0] r_sr;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_dv;
  logic             r_bs;
  logic             w_slip;
  logic             w_fsm_slip;

  // External and internal slips merge into a single slip event.
  assign w_slip = (bus.bitslip & ~r_bs) | w_fsm_slip;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_dv  <= 1'b0;
      r_bs  <= 1'b0;
    end else begin
      // Edge register tracks bitslip even while sampling is disabled.
      r_bs <= bus.bitslip;
      r_dv <= 1'b0;
      if (bus.en) begin
        r_sr <= {r_sr[WIDTH-3:0], bus.d};
        // A slip shifts data but holds the counter, pushing the boundary one bit later.
        if (!w_slip) begin
          if (r_cnt == CntMax) begin
            r_cnt <= '0;
            r_q   <= {r_sr, bus.d};
            r_dv  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.q          = r_q;
  assign bus.data_valid = r_dv;

`ifdef I_DESER_AUTO_ALIGN_EN
  localparam int unsigned TriesW = $clog2(WIDTH + 1);
  localparam logic [TriesW-1:0] TriesMax = TriesW'(WIDTH);
  localparam logic [WIDTH-1:0] TrainWord = TRAIN_PATTERN[WIDTH-1:0];

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StWait,
    StLocked,
    StFail
  } state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic [TriesW-1:0] r_tries;
  logic [TriesW-1:0] w_tries_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_tries <= '0;
    end else begin
      r_state <= w_state_d;
      r_tries <= w_tries_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_tries_d  = r_tries;
    w_fsm_slip = 1'b0;
    case (r_state)
      StIdle, StLocked, StFail: begin
        if (bus.align_start) begin
          w_tries_d = '0;
          w_state_d = StCheck;
        end
      end
      StCheck: begin
        if (r_dv) begin
          if (r_q == TrainWord) begin
            w_state_d = StLocked;
          end else if (r_tries == TriesMax) begin
            w_state_d = StFail;
          end else begin
            w_fsm_slip = 1'b1;
            w_tries_d  = r_tries + 1'b1;
            w_state_d  = StWait;
          end
        end
      end
      // The first word after a slip is skipped before the next comparison.
      StWait: begin
        if (r_dv) begin
          w_state_d = StCheck;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign bus.aligned    = (r_state == StLocked);
  assign bus.align_fail = (r_state == StFail);
`else
  logic w_unused;

  assign w_fsm_slip     = 1'b0;
  assign bus.aligned    = 1'b0;
  assign bus.align_fail = 1'b0;
  assign w_unused       = bus.align_start ^ (^TRAIN_PATTERN);
`endif

endmodule
